fifo_req: RTL and testbench

- Per-port input FIFO that sits directly upstream of the two-port round-robin arbiter/mux. Two instances are used, one for port 0 and one for port 1.
- Buffers incoming words and presents a non-empty request (request) to the arbiter.
- Accepts the arbiter's registered pop and returns the head word with a valid strobe one cycle later.
- Generates almost-full/almost-empty flow-control flags and a sticky error flag.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 39 +++
 rtl/fifo_req.sv | 98 +++++++++
 tb/tb_fifo_req.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and reset values for the per-port request FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_DEPTH  = 4;

  localparam logic RST_VALID = 1'b0;
  localparam logic RST_ERROR = 1'b0;
  localparam logic RST_DBIT  = 1'b0;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so that count can represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Array carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) rd_data_q <= {DATA_W{RST_DBIT}};
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_req.sv
// Per-port input FIFO feeding the round-robin arbiter: pointers, count,
// flow-control flags and a sticky overflow/underflow flag.
module fifo_req
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_THR = 3,
  parameter int AE_THR = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              request,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THR);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THR);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             push_ok, pop_ok, overflow, underflow;

  // A pop only succeeds against stored data; a push into a full FIFO is
  // allowed when the same-cycle pop frees the slot it will land in.
  assign pop_ok    = pop && (count_q != '0);
  assign push_ok   = push && ((count_q != DEPTH_C) || pop_ok);
  assign overflow  = push && (count_q == DEPTH_C) && !pop_ok;
  assign underflow = pop && (count_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop_ok;
    error_d  = error_q | overflow | underflow;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= RST_VALID;
      error_q  <= RST_ERROR;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign valid_out    = valid_q;
  assign error        = error_q;
  assign request      = (count_q != '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_fifo_req.sv
// Bench for fifo_req: vector table for flag/data timing, scoreboard for streams.
module tb_fifo_req;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push, pop;
  logic [5:0] data_in;
  logic [5:0] data_out;
  logic       valid_out, request, full, almost_full, almost_empty, error;

  int checks = 0;
  int errors = 0;
  bit sb_en  = 1'b0;
  logic [5:0] sbq[$];

  always #5 clk = ~clk;

  fifo_req #(.DATA_W(6), .DEPTH(4), .AF_THR(3), .AE_THR(1)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .request      (request),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  typedef struct {
    logic       push;
    logic [5:0] din;
    logic       pop;
    logic [11:0] exp; // {req,full,af,ae,vld,dout[5:0],err}
  } vec_t;

  function automatic vec_t mk(input logic p, input logic [5:0] d, input logic po,
                              input logic rq, input logic fl, input logic af,
                              input logic ae, input logic vl, input logic [5:0] dq,
                              input logic er);
    vec_t v;
    v.push = p; v.din = d; v.pop = po;
    v.exp  = {rq, fl, af, ae, vl, dq, er};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic [5:0] d, input logic po);
    logic [5:0] e;
    push = p; data_in = d; pop = po;
    @(posedge clk);
    #1;
    if (sb_en && valid_out) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", 32'(data_out), 32'(e));
      end
    end
  endtask

  task automatic put(input logic [5:0] d, input logic po);
    sbq.push_back(d);
    step(1'b1, d, po);
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; data_in = '0;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    sbq.delete();
  endtask

  vec_t vt[9];

  initial begin
    push = 1'b0; pop = 1'b0; data_in = '0; reset_L = 1'b0;
    // Overflow scenario: fill, drop 0x3F, drain 0x01..0x04.
    vt[0] = mk(1'b1, 6'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0);
    vt[1] = mk(1'b1, 6'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    vt[2] = mk(1'b1, 6'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
    vt[3] = mk(1'b1, 6'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
    vt[4] = mk(1'b1, 6'h3F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1);
    vt[5] = mk(1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h01, 1'b1);
    vt[6] = mk(1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h02, 1'b1);
    vt[7] = mk(1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h03, 1'b1);
    vt[8] = mk(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h04, 1'b1);

    do_reset();
    step(1'b0, 6'h00, 1'b0);
    chk("reset_state", 32'({request, full, almost_full, almost_empty, valid_out, data_out, error}),
        32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0}));

    for (int i = 0; i < 9; i++) begin
      step(vt[i].push, vt[i].din, vt[i].pop);
      chk($sformatf("vec%0d", i),
          32'({request, full, almost_full, almost_empty, valid_out, data_out, error}),
          32'(vt[i].exp));
    end
    step(1'b0, 6'h00, 1'b0);
    chk("idle_after_drain_valid", 32'(valid_out), 32'd0);

    // Drain four then underflow on the fifth pop.
    do_reset();
    sb_en = 1'b1;
    for (int i = 1; i <= 4; i++) put(6'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 6'h00, 1'b1);
    chk("drain_empty_request", 32'(request), 32'd0);
    chk("drain_no_error", 32'(error), 32'd0);
    step(1'b0, 6'h00, 1'b1);
    chk("underflow_valid", 32'(valid_out), 32'd0);
    chk("underflow_error", 32'(error), 32'd1);
    chk("underflow_data_held", 32'(data_out), 32'h04);
    chk("drain_sb_empty", 32'(sbq.size()), 32'd0);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) put(6'h0A + 6'(i), 1'b0);
    chk("full_before", 32'(full), 32'd1);
    put(6'h2A, 1'b1);
    chk("full_pp_full", 32'(full), 32'd1);
    chk("full_pp_error", 32'(error), 32'd0);
    chk("full_pp_valid", 32'(valid_out), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 6'h00, 1'b1);
    chk("full_pp_sb_empty", 32'(sbq.size()), 32'd0);
    chk("full_pp_request", 32'(request), 32'd0);

    // Pointer wrap: push with pop lagging by one cycle.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) put(6'h10 + 6'(i), (i >= 1));
      else        step(1'b0, 6'h00, 1'b1);
    end
    chk("wrap_sb_empty", 32'(sbq.size()), 32'd0);
    chk("wrap_error", 32'(error), 32'd0);
    chk("wrap_request", 32'(request), 32'd0);

    // Empty with simultaneous push and pop: pop rejected, push kept.
    do_reset();
    put(6'h21, 1'b1);
    chk("empty_pp_valid", 32'(valid_out), 32'd0);
    chk("empty_pp_request", 32'(request), 32'd1);
    chk("empty_pp_error", 32'(error), 32'd1);
    step(1'b0, 6'h00, 1'b1);
    chk("empty_pp_sb_empty", 32'(sbq.size()), 32'd0);

    // Asynchronous reset mid-stream.
    do_reset();
    put(6'h31, 1'b0);
    put(6'h32, 1'b0);
    step(1'b0, 6'h00, 1'b1);
    step(1'b0, 6'h00, 1'b0);
    push = 1'b0; pop = 1'b0;
    #3 reset_L = 1'b0;
    #1;
    chk("async_rst_request", 32'(request), 32'd0);
    chk("async_rst_valid", 32'(valid_out), 32'd0);
    chk("async_rst_data", 32'(data_out), 32'd0);
    #2 reset_L = 1'b1;
    sbq.delete();
    put(6'h05, 1'b0);
    step(1'b0, 6'h00, 1'b1);
    chk("post_rst_valid", 32'(valid_out), 32'd1);
    chk("post_rst_sb_empty", 32'(sbq.size()), 32'd0);
    chk("post_rst_error", 32'(error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
